// File: rtl/elevator_call_dispatcher.sv
// Elevator call dispatcher: latches hall and car calls for a 4-floor car, picks the next
// target with a SCAN (keep-direction) policy, issues it to the floor state machine, waits
// for arrival and times the door dwell at each served floor.
//
// Ports
//   clk_i           rising-edge clock
//   rst_ni          synchronous active-low reset
//   hall_call_i     hall (outer) call buttons, bit i = floor i
//   car_call_i      car (inner) call buttons, bit i = floor i
//   cur_floor_i     current floor code from the floor state machine
//   outer_button_o  issued target has a pending hall call
//   inner_button_o  issued target floor code
//   req_valid_o     outer/inner_button valid; held high through travel
//   door_open_o     door dwell in progress
//   pending_o       OR of latched hall and car calls
//   timeout_err_o   sticky: car failed to reach a target in time
module elevator_call_dispatcher #(
  parameter int unsigned DWELL_CYCLES   = 8,
  parameter int unsigned TIMEOUT_CYCLES = 200,
  parameter int unsigned CNT_W          = 8
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [3:0] hall_call_i,
  input  logic [3:0] car_call_i,
  input  logic [1:0] cur_floor_i,
  output logic       outer_button_o,
  output logic [1:0] inner_button_o,
  output logic       req_valid_o,
  output logic       door_open_o,
  output logic [3:0] pending_o,
  output logic       timeout_err_o
);

  typedef enum logic [1:0] {StIdle, StIssue, StTravel, StDoor} state_e;

  state_e             state_q, state_d;
  logic [3:0]         hall_q, hall_d;
  logic [3:0]         car_q, car_d;
  logic               dir_up_q, dir_up_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         target_q, target_d;
  logic               outer_q, outer_d;
  logic               req_q, req_d;
  logic               door_q, door_d;
  logic               err_q, err_d;

  logic [3:0]         pending;
  logic [3:0]         cur_oh;
  logic [3:0]         clr_mask;
  logic [CNT_W-1:0]   cnt_inc;
  logic               found_up, found_dn;
  logic [1:0]         up_floor, dn_floor;

  assign pending = hall_q | car_q;
  assign cur_oh  = 4'b0001 << cur_floor_i;
  assign cnt_inc = cnt_q + CNT_W'(1);

  // Nearest pending floor above / below the car. The up scan runs downwards so the last hit
  // is the closest one; the down scan runs upwards for the same reason.
  always_comb begin
    found_up = 1'b0;
    up_floor = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (2'(i) > cur_floor_i && pending[2'(i)]) begin
        found_up = 1'b1;
        up_floor = 2'(i);
      end
    end
    found_dn = 1'b0;
    dn_floor = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (2'(i) < cur_floor_i && pending[2'(i)]) begin
        found_dn = 1'b1;
        dn_floor = 2'(i);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    hall_d   = hall_q | hall_call_i;
    car_d    = car_q | car_call_i;
    dir_up_d = dir_up_q;
    cnt_d    = cnt_q;
    target_d = target_q;
    outer_d  = outer_q;
    req_d    = req_q;
    door_d   = door_q;
    err_d    = err_q;
    clr_mask = 4'b0000;

    unique case (state_q)
      StIdle: begin
        if (pending != 4'b0000) begin
          if ((pending & cur_oh) != 4'b0000) begin
            state_d  = StDoor;
            cnt_d    = CNT_W'(DWELL_CYCLES);
            door_d   = 1'b1;
            clr_mask = cur_oh;
          end else begin
            if (dir_up_q) begin
              if (found_up) begin
                target_d = up_floor;
              end else begin
                dir_up_d = 1'b0;
                target_d = dn_floor;
              end
            end else begin
              if (found_dn) begin
                target_d = dn_floor;
              end else begin
                dir_up_d = 1'b1;
                target_d = up_floor;
              end
            end
            // Request is registered on the way into ISSUE so it is visible during ISSUE.
            state_d = StIssue;
            req_d   = 1'b1;
            cnt_d   = '0;
          end
        end
      end
      StIssue: begin
        cnt_d   = '0;
        state_d = StTravel;
      end
      StTravel: begin
        // Arrival is tested first so it wins over a coincident timeout.
        if (cur_floor_i == target_q) begin
          state_d  = StDoor;
          req_d    = 1'b0;
          cnt_d    = CNT_W'(DWELL_CYCLES);
          door_d   = 1'b1;
          clr_mask = cur_oh;
        end else if (cnt_inc >= CNT_W'(TIMEOUT_CYCLES)) begin
          state_d  = StIdle;
          req_d    = 1'b0;
          err_d    = 1'b1;
          cnt_d    = cnt_inc;
          clr_mask = 4'b0001 << target_q;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StDoor: begin
        // Calls for the floor with the door open are dropped.
        clr_mask = cur_oh;
        cnt_d    = cnt_q - CNT_W'(1);
        if (cnt_q <= CNT_W'(1)) begin
          state_d = StIdle;
          door_d  = 1'b0;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    hall_d = hall_d & ~clr_mask;
    car_d  = car_d & ~clr_mask;

    // While a request is live, outer_button mirrors the hall latch of the target floor.
    if (state_d == StIssue || state_d == StTravel) begin
      outer_d = hall_d[target_d];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      hall_q   <= 4'b0000;
      car_q    <= 4'b0000;
      dir_up_q <= 1'b1;
      cnt_q    <= '0;
      target_q <= 2'd0;
      outer_q  <= 1'b0;
      req_q    <= 1'b0;
      door_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      hall_q   <= hall_d;
      car_q    <= car_d;
      dir_up_q <= dir_up_d;
      cnt_q    <= cnt_d;
      target_q <= target_d;
      outer_q  <= outer_d;
      req_q    <= req_d;
      door_q   <= door_d;
      err_q    <= err_d;
    end
  end

  assign outer_button_o = outer_q;
  assign inner_button_o = target_q;
  assign req_valid_o    = req_q;
  assign door_open_o    = door_q;
  assign pending_o      = pending;
  assign timeout_err_o  = err_q;

endmodule
